// File: rtl/dispatch_unit_pkg.sv
// Shared types for the dispatch stage: RV32 opcode constants, reservation-station
// class encoding and the opcode classifier.
package dispatch_unit_pkg;

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;

  typedef enum logic [1:0] {
    CLS_ALU  = 2'd0,
    CLS_LSU  = 2'd1,
    CLS_BRU  = 2'd2,
    CLS_NONE = 2'd3
  } rs_class_e;

  // CLS_NONE marks an unrecognised opcode: it needs no credit and is retired silently.
  function automatic rs_class_e classify_opcode(input logic [OPC_W-1:0] opcode);
    rs_class_e cls;
    case (opcode)
      OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC, OPC_SYSTEM: cls = CLS_ALU;
      OPC_LOAD, OPC_STORE:                                cls = CLS_LSU;
      OPC_BRANCH, OPC_JAL, OPC_JALR:                      cls = CLS_BRU;
      default:                                            cls = CLS_NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/dispatch_credit_counter.sv
// Per-class reservation-station credit counter: adds freed entries, subtracts
// grants, saturates at RS_DEPTH and reloads to RS_DEPTH on flush.
module dispatch_credit_counter #(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned CRED_W   = $clog2(RS_DEPTH + 1),
  parameter int unsigned CNT_W    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [CNT_W-1:0]  free_cnt,
  input  logic [CNT_W-1:0]  grant_cnt,
  output logic [CRED_W-1:0] credit
);

  localparam int unsigned SUM_W = ((CRED_W > CNT_W) ? CRED_W : CNT_W) + 1;

  logic [CRED_W-1:0] credit_q, credit_d;
  logic [SUM_W-1:0]  sum_c;
  logic              ovf_c;

  // Grants never exceed the current credit, so the sum cannot wrap below zero.
  always_comb begin
    sum_c    = SUM_W'(credit_q) + SUM_W'(free_cnt) - SUM_W'(grant_cnt);
    ovf_c    = (sum_c > SUM_W'(RS_DEPTH));
    credit_d = CRED_W'(sum_c);
    if (flush || ovf_c) begin
      credit_d = CRED_W'(RS_DEPTH);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      credit_q <= CRED_W'(RS_DEPTH);
    end else begin
      credit_q <= credit_d;
    end
  end

  always @(posedge clk) begin
    if (rst && !flush) begin
      assert (!ovf_c) else $error("dispatch_credit_counter: credit overflow above RS_DEPTH");
    end
  end

  assign credit = credit_q;

endmodule

// File: rtl/dispatch_unit.sv
// N-wide in-order dispatch from rename into the ALU/LSU/BRU reservation stations,
// gated by per-class credits; lanes issue strictly in program order.
module dispatch_unit
  import dispatch_unit_pkg::*;
#(
  parameter int unsigned DISPATCH_WIDTH = 2,
  parameter int unsigned INST_W         = 128,
  parameter int unsigned NUM_CLASSES    = 3,
  parameter int unsigned RS_DEPTH       = 16,
  parameter int unsigned CRED_W         = $clog2(RS_DEPTH + 1)
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  flush,
  input  logic                                  stall_dispatch,
  input  logic [DISPATCH_WIDTH-1:0]             in_valid,
  input  logic [DISPATCH_WIDTH*7-1:0]           in_opcode,
  input  logic [DISPATCH_WIDTH*INST_W-1:0]      in_inst,
  output logic                                  in_ready,
  input  logic [NUM_CLASSES*DISPATCH_WIDTH-1:0] rs_free,
  output logic [NUM_CLASSES*DISPATCH_WIDTH-1:0] out_valid,
  output logic [DISPATCH_WIDTH*INST_W-1:0]      out_inst,
  output logic                                  illegal_valid,
  output logic [$clog2(DISPATCH_WIDTH):0]       illegal_lane
);

  localparam int unsigned W      = DISPATCH_WIDTH;
  localparam int unsigned CNT_W  = $clog2(W + 1);
  localparam int unsigned LANE_W = $clog2(W) + 1;
  localparam int unsigned CMP_W  = (CRED_W > CNT_W) ? CRED_W : CNT_W;

  logic [W-1:0]          pend_q, pend_d;
  rs_class_e             cls_q [W];
  rs_class_e             cls_d [W];
  logic [W*INST_W-1:0]   inst_q, inst_d;

  logic [NUM_CLASSES*W-1:0] out_valid_q, out_valid_d;
  logic [W*INST_W-1:0]      out_inst_q, out_inst_d;
  logic                     ill_v_q, ill_v_d;
  logic [LANE_W-1:0]        ill_lane_q, ill_lane_d;

  logic [W-1:0]                   grant_c;
  logic [NUM_CLASSES*CRED_W-1:0]  credit_c;
  logic [NUM_CLASSES*CNT_W-1:0]   free_cnt_c;
  logic [NUM_CLASSES*CNT_W-1:0]   grant_cnt_c;
  logic                           go_c;
  logic                           all_done_c;
  logic                           accept_c;

  assign go_c = !stall_dispatch && !flush;

  // Prefix scan: a lane issues only if every lower pending lane issues and its
  // class still has credit after the lower same-class grants of this cycle.
  for (genvar i = 0; i < W; i++) begin : g_lane
    logic                          ok_in, ok_out, has_credit, lane_grant;
    logic [NUM_CLASSES*CNT_W-1:0]  used_in, used_out;

    if (i == 0) begin : g_first
      assign ok_in   = 1'b1;
      assign used_in = '0;
    end else begin : g_next
      assign ok_in   = g_lane[i-1].ok_out;
      assign used_in = g_lane[i-1].used_out;
    end

    always_comb begin
      has_credit = (cls_q[i] == CLS_NONE);
      used_out   = used_in;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (int'(cls_q[i]) == c) begin
          has_credit = CMP_W'(credit_c[c*CRED_W +: CRED_W]) > CMP_W'(used_in[c*CNT_W +: CNT_W]);
        end
      end
      lane_grant = pend_q[i] && ok_in && has_credit && go_c;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        if (lane_grant && int'(cls_q[i]) == c) begin
          used_out[c*CNT_W +: CNT_W] = used_in[c*CNT_W +: CNT_W] + CNT_W'(1);
        end
      end
      ok_out = ok_in && (!pend_q[i] || lane_grant);
    end

    assign grant_c[i] = lane_grant;
  end

  assign all_done_c  = g_lane[W-1].ok_out;
  assign grant_cnt_c = g_lane[W-1].used_out;
  assign in_ready    = rst && go_c && all_done_c;
  assign accept_c    = in_valid[0] && in_ready;

  always_comb begin
    free_cnt_c = '0;
    for (int c = 0; c < NUM_CLASSES; c++) begin
      for (int i = 0; i < W; i++) begin
        free_cnt_c[c*CNT_W +: CNT_W] = free_cnt_c[c*CNT_W +: CNT_W] + CNT_W'(rs_free[c*W+i]);
      end
    end
  end

  for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cred
    dispatch_credit_counter #(
      .RS_DEPTH (RS_DEPTH),
      .CRED_W   (CRED_W),
      .CNT_W    (CNT_W)
    ) u_cred (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .free_cnt  (free_cnt_c[c*CNT_W +: CNT_W]),
      .grant_cnt (grant_cnt_c[c*CNT_W +: CNT_W]),
      .credit    (credit_c[c*CRED_W +: CRED_W])
    );
  end

  // Buffer update and registered per-class issue outputs.
  always_comb begin
    pend_d      = pend_q & ~grant_c;
    cls_d       = cls_q;
    inst_d      = inst_q;
    out_valid_d = '0;
    out_inst_d  = out_inst_q;
    ill_v_d     = 1'b0;
    ill_lane_d  = '0;

    if (flush) begin
      pend_d = '0;
    end else if (accept_c) begin
      pend_d = in_valid;
      inst_d = in_inst;
      for (int i = 0; i < W; i++) begin
        cls_d[i] = classify_opcode(in_opcode[i*7 +: 7]);
      end
    end

    for (int i = 0; i < W; i++) begin
      if (grant_c[i]) begin
        out_inst_d[i*INST_W +: INST_W] = inst_q[i*INST_W +: INST_W];
        if (cls_q[i] == CLS_NONE) begin
          if (!ill_v_d) begin
            ill_v_d    = 1'b1;
            ill_lane_d = LANE_W'(i);
          end
        end else begin
          for (int c = 0; c < NUM_CLASSES; c++) begin
            if (int'(cls_q[i]) == c) begin
              out_valid_d[c*W+i] = 1'b1;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q      <= '0;
      inst_q      <= '0;
      out_valid_q <= '0;
      out_inst_q  <= '0;
      ill_v_q     <= 1'b0;
      ill_lane_q  <= '0;
      for (int i = 0; i < W; i++) begin
        cls_q[i] <= CLS_NONE;
      end
    end else begin
      pend_q      <= pend_d;
      inst_q      <= inst_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      ill_v_q     <= ill_v_d;
      ill_lane_q  <= ill_lane_d;
      for (int i = 0; i < W; i++) begin
        cls_q[i] <= cls_d[i];
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      assert ((in_valid & W'(in_valid + W'(1))) == '0)
        else $error("dispatch_unit: in_valid lanes not contiguous from lane 0");
    end
  end

  assign out_valid     = out_valid_q;
  assign out_inst      = out_inst_q;
  assign illegal_valid = ill_v_q;
  assign illegal_lane  = ill_lane_q;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit (W=2, RS_DEPTH=4) with a queue-level model
// checked every cycle plus hand-computed expectations.
module tb_dispatch_unit;

  localparam int W     = 2;
  localparam int IW    = 32;
  localparam int NC    = 3;
  localparam int DEPTH = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              flush;
  logic              stall;
  logic [W-1:0]      in_valid;
  logic [W*7-1:0]    in_opcode;
  logic [W*IW-1:0]   in_inst;
  logic              in_ready;
  logic [NC*W-1:0]   rs_free;
  logic [NC*W-1:0]   out_valid;
  logic [W*IW-1:0]   out_inst;
  logic              illegal_valid;
  logic [1:0]        illegal_lane;

  int checks = 0;
  int errors = 0;

  dispatch_unit #(
    .DISPATCH_WIDTH (W),
    .INST_W         (IW),
    .NUM_CLASSES    (NC),
    .RS_DEPTH       (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stall_dispatch (stall),
    .in_valid       (in_valid),
    .in_opcode      (in_opcode),
    .in_inst        (in_inst),
    .in_ready       (in_ready),
    .rs_free        (rs_free),
    .out_valid      (out_valid),
    .out_inst       (out_inst),
    .illegal_valid  (illegal_valid),
    .illegal_lane   (illegal_lane)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int               m_cred [NC];
  bit               m_pend [W];
  int               m_cls  [W];
  logic [IW-1:0]    m_inst [W];
  logic [NC*W-1:0]  e_ov;
  logic [W*IW-1:0]  e_inst;
  logic             e_iv;
  logic [1:0]       e_il;
  logic [W-1:0]     mg;
  bit               macc;
  int               n;

  function automatic int cls_of(input logic [6:0] op);
    case (op)
      7'h33, 7'h13, 7'h37, 7'h17, 7'h73: return 0;
      7'h03, 7'h23:                      return 1;
      7'h63, 7'h6f, 7'h67:               return 2;
      default:                           return 3;
    endcase
  endfunction

  function automatic logic [W-1:0] m_grants();
    logic [W-1:0] g;
    int left [NC];
    bit blocked;
    g = '0;
    if (stall || flush) return g;
    left = m_cred;
    blocked = 1'b0;
    for (int i = 0; i < W; i++) begin
      if (m_pend[i] && !blocked) begin
        if (m_cls[i] == 3) g[i] = 1'b1;
        else if (left[m_cls[i]] > 0) begin
          g[i] = 1'b1;
          left[m_cls[i]]--;
        end else blocked = 1'b1;
      end
    end
    return g;
  endfunction

  function automatic bit m_ready();
    logic [W-1:0] g;
    g = m_grants();
    if (!rst || stall || flush) return 1'b0;
    for (int i = 0; i < W; i++) if (m_pend[i] && !g[i]) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NC; c++) m_cred[c] = DEPTH;
      for (int i = 0; i < W; i++) begin
        m_pend[i] = 1'b0;
        m_cls[i]  = 3;
        m_inst[i] = '0;
      end
      e_ov = '0; e_inst = '0; e_iv = 1'b0; e_il = '0;
    end else begin
      mg   = m_grants();
      macc = in_valid[0] && m_ready();
      e_ov = '0; e_iv = 1'b0; e_il = '0;
      for (int i = 0; i < W; i++) begin
        if (mg[i]) begin
          e_inst[i*IW +: IW] = m_inst[i];
          if (m_cls[i] == 3) begin
            if (!e_iv) begin e_iv = 1'b1; e_il = 2'(i); end
          end else e_ov[m_cls[i]*W+i] = 1'b1;
        end
      end
      for (int c = 0; c < NC; c++) begin
        if (flush) m_cred[c] = DEPTH;
        else begin
          n = m_cred[c];
          for (int i = 0; i < W; i++) begin
            n += int'(rs_free[c*W+i]);
            if (mg[i] && m_cls[i] == c) n--;
          end
          m_cred[c] = (n > DEPTH) ? DEPTH : n;
        end
      end
      for (int i = 0; i < W; i++) begin
        if (flush) m_pend[i] = 1'b0;
        else if (macc) begin
          m_pend[i] = in_valid[i];
          m_cls[i]  = cls_of(in_opcode[i*7 +: 7]);
          m_inst[i] = in_inst[i*IW +: IW];
        end else if (mg[i]) m_pend[i] = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    chk("cyc_out_valid", 64'(out_valid), 64'(e_ov));
    chk("cyc_out_inst", 64'(out_inst), 64'(e_inst));
    chk("cyc_illegal_valid", 64'(illegal_valid), 64'(e_iv));
    if (e_iv) chk("cyc_illegal_lane", 64'(illegal_lane), 64'(e_il));
    chk("cyc_in_ready", 64'(in_ready), 64'(m_ready()));
  end

  // ---------------- stimulus ----------------
  task tick();
    @(posedge clk);
    #1;
  endtask

  task offer(input logic [W-1:0] v, input logic [6:0] o0, input logic [6:0] o1,
             input logic [IW-1:0] i0, input logic [IW-1:0] i1);
    in_valid  = v;
    in_opcode = {o1, o0};
    in_inst   = {i1, i0};
  endtask

  task idle();
    in_valid = '0;
  endtask

  task do_reset();
    flush = 1'b0; stall = 1'b0; rs_free = '0; in_valid = '0;
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; stall = 1'b0; rs_free = '0;
    in_valid = '0; in_opcode = '0; in_inst = '0;
    tick();
    tick();
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_inst", 64'(out_inst), 64'd0);
    rst = 1'b1;
    #1 chk("ready_after_reset", 64'(in_ready), 64'd1);

    // ALU + LSU group
    offer(2'b11, 7'h33, 7'h03, 32'hA0A0_0000, 32'hA1A1_0001);
    #1 chk("t1_ready", 64'(in_ready), 64'd1);
    tick(); idle();
    tick();
    chk("t1_out_valid", 64'(out_valid), 64'b001001);
    chk("t1_out_inst", 64'(out_inst), {32'hA1A1_0001, 32'hA0A0_0000});
    chk("t1_cred_alu", 64'(m_cred[0]), 64'd3);
    chk("t1_cred_lsu", 64'(m_cred[1]), 64'd3);

    // ALU credit exhaustion blocks a later BRU lane
    do_reset();
    offer(2'b11, 7'h33, 7'h13, 32'hB0, 32'hB1); tick();
    offer(2'b11, 7'h33, 7'h37, 32'hB2, 32'hB3); tick();
    chk("t2_g1_out", 64'(out_valid), 64'b000011);
    offer(2'b11, 7'h33, 7'h63, 32'hB4, 32'hB5); tick();
    idle();
    chk("t2_g2_out", 64'(out_valid), 64'b000011);
    chk("t2_cred_zero", 64'(m_cred[0]), 64'd0);
    #1 chk("t2_blocked_ready", 64'(in_ready), 64'd0);
    tick();
    chk("t2_hold_out_a", 64'(out_valid), 64'd0);
    tick();
    chk("t2_hold_out_b", 64'(out_valid), 64'd0);
    chk("t2_hold_ready", 64'(in_ready), 64'd0);
    rs_free = 6'b000001; tick(); rs_free = '0;
    #1 chk("t2_ready_after_free", 64'(in_ready), 64'd1);
    tick();
    chk("t2_release_out", 64'(out_valid), 64'b100001);
    chk("t2_release_inst", 64'(out_inst), {32'hB5, 32'hB4});
    chk("t2_cred_alu", 64'(m_cred[0]), 64'd0);
    chk("t2_cred_bru", 64'(m_cred[2]), 64'd3);

    // partial group with same-cycle free
    do_reset();
    offer(2'b11, 7'h33, 7'h33, 32'hC0, 32'hC1); tick();
    offer(2'b11, 7'h33, 7'h23, 32'hC2, 32'hC3); tick();
    offer(2'b11, 7'h17, 7'h73, 32'hC4, 32'hC5); tick();
    idle();
    chk("t3_g2_out", 64'(out_valid), 64'b001001);
    chk("t3_cred_one", 64'(m_cred[0]), 64'd1);
    #1 chk("t3_partial_ready", 64'(in_ready), 64'd0);
    rs_free = 6'b000001; tick(); rs_free = '0;
    chk("t3_lane0_out", 64'(out_valid), 64'b000001);
    chk("t3_cred_net", 64'(m_cred[0]), 64'd1);
    #1 chk("t3_ready_lane1", 64'(in_ready), 64'd1);
    tick();
    chk("t3_lane1_out", 64'(out_valid), 64'b000010);
    chk("t3_lane1_inst", 64'(out_inst), {32'hC5, 32'hC4});

    // flush with a pending blocked lane
    do_reset();
    offer(2'b11, 7'h33, 7'h33, 32'hD0, 32'hD1); tick();
    offer(2'b11, 7'h33, 7'h33, 32'hD2, 32'hD3); tick();
    offer(2'b11, 7'h6f, 7'h33, 32'hD4, 32'hD5); tick();
    idle(); tick();
    chk("t4_bru_out", 64'(out_valid), 64'b010000);
    flush = 1'b1; rs_free = 6'b111111;
    #1 chk("t4_flush_ready", 64'(in_ready), 64'd0);
    tick();
    flush = 1'b0; rs_free = '0;
    chk("t4_flush_out", 64'(out_valid), 64'd0);
    chk("t4_cred_alu", 64'(m_cred[0]), 64'd4);
    chk("t4_cred_bru", 64'(m_cred[2]), 64'd4);
    #1 chk("t4_ready_after", 64'(in_ready), 64'd1);
    tick();
    chk("t4_no_lane1", 64'(out_valid), 64'd0);

    // stall before and after acceptance
    do_reset();
    stall = 1'b1;
    offer(2'b11, 7'h33, 7'h03, 32'hE0, 32'hE1);
    #1 chk("t5_stall_ready", 64'(in_ready), 64'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t5_stall_out", 64'(out_valid), 64'd0);
      chk("t5_stall_ready_k", 64'(in_ready), 64'd0);
    end
    stall = 1'b0;
    #1 chk("t5_ready_drop", 64'(in_ready), 64'd1);
    tick(); idle();
    stall = 1'b1; tick();
    chk("t5_stall_pending", 64'(out_valid), 64'd0);
    stall = 1'b0; tick();
    chk("t5_out", 64'(out_valid), 64'b001001);
    chk("t5_inst", 64'(out_inst), {32'hE1, 32'hE0});

    // illegal lane, then asynchronous reset mid-group
    do_reset();
    offer(2'b11, 7'h00, 7'h33, 32'hF0, 32'hF1); tick();
    offer(2'b11, 7'h33, 7'h33, 32'hF2, 32'hF3); tick();
    idle();
    chk("t6_illegal_valid", 64'(illegal_valid), 64'd1);
    chk("t6_illegal_lane", 64'(illegal_lane), 64'd0);
    chk("t6_out_valid", 64'(out_valid), 64'b000010);
    chk("t6_cred_alu", 64'(m_cred[0]), 64'd3);
    rst = 1'b0;
    #1;
    chk("t6_rst_out_valid", 64'(out_valid), 64'd0);
    chk("t6_rst_illegal", 64'(illegal_valid), 64'd0);
    chk("t6_rst_inst", 64'(out_inst), 64'd0);
    chk("t6_rst_ready", 64'(in_ready), 64'd0);
    tick(); rst = 1'b1;
    tick();
    chk("t6_discard_a", 64'(out_valid), 64'd0);
    tick();
    chk("t6_discard_b", 64'(out_valid), 64'd0);

    // illegal on lane 1 behind an LSU lane
    offer(2'b11, 7'h03, 7'h7f, 32'h10, 32'h11); tick();
    idle(); tick();
    chk("t7_illegal_valid", 64'(illegal_valid), 64'd1);
    chk("t7_illegal_lane", 64'(illegal_lane), 64'd1);
    chk("t7_out_valid", 64'(out_valid), 64'b000100);
    chk("t7_cred_lsu", 64'(m_cred[1]), 64'd3);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dispatch_unit.md
Name: dispatch_unit

Overview:
- Parametrised N-wide in-order dispatch stage between rename and the per-class reservation stations (ALU, LSU, BRU).
- Classifies each lane by RV32 opcode and holds the renamed group in a buffer.
- Issues lanes to the reservation stations in program order using per-class credit counters instead of a busy signal.
- Supports partial-group dispatch, flush, and stall.

Parameters:
- DISPATCH_WIDTH, 2: lanes per group (W), 1..4.
- INST_W, 128: flattened renamed-instruction payload width per lane.
- NUM_CLASSES, 3: RS classes; 0=ALU, 1=LSU, 2=BRU.
- RS_DEPTH, 16: entries per reservation station; initial credit value.
- CRED_W, $clog2(RS_DEPTH+1): credit counter width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- flush  in  1  pipeline flush
- stall_dispatch  in  1  freeze dispatch
- in_valid  in  W  per-lane valid; lanes contiguous from lane 0
- in_opcode  in  W*7  per-lane opcode
- in_inst  in  W*INST_W  per-lane renamed payload
- in_ready  out  1  group accepted when in_valid[0] && in_ready
- rs_free  in  NUM_CLASSES*W  per-class entry-freed pulses; popcount per class per cycle
- out_valid  out  NUM_CLASSES*W  bit c*W+i: lane i written to RS c
- out_inst  out  W*INST_W  per-lane payload, shared by all classes
- illegal_valid  out  1  unrecognised opcode retired from the group
- illegal_lane  out  $clog2(W)+1  lane index of the first illegal lane this cycle

Behaviour:
- Opcode classes:
  - ALU: OP_IMM, OP, LUI, AUIPC, SYSTEM.
  - LSU: LOAD, STORE.
  - BRU: BRANCH, JAL, JALR.
  - Anything else is illegal: it needs no credit and is consumed silently.
- Holding buffer: W lanes, each with a pending bit, payload and 2-bit class. Load occurs on acceptance with pending = in_valid.
- Selection, each cycle (combinational): scan pending lanes from the lowest index.
  - Lane i dispatches iff all lower pending lanes dispatch this cycle and credit[cls] minus the earlier same-class grants this cycle is greater than 0.
  - Illegal lanes always "dispatch".
  - The first blocked lane blocks every higher lane. No reordering.
- Output latency is 1 cycle: a lane granted in cycle t produces out_valid/out_inst in t+1 (registered). Its pending bit clears at the t edge.
- in_ready = (no pending lanes) OR (all pending lanes granted this cycle), AND !stall_dispatch AND !flush. This allows back-to-back groups with no bubble.
- Credits, per class, updated at each edge: credit += popcount(rs_free[c]) − grants[c].
  - Simultaneous free and grant nets out.
  - Overflow above RS_DEPTH saturates and fires a simulation assertion.
  - Underflow cannot occur by construction.
- stall_dispatch: no grants, no loads, out_valid = 0 next cycle. Buffer, credits and rs_free accounting continue.
- flush (priority over everything):
  - Clear all pending bits.
  - out_valid = 0 next cycle.
  - Credits reload to RS_DEPTH; rs_free is ignored that cycle.
  - in_ready = 0.
- Reset values: all pending = 0, out_valid = 0, out_inst = 0, illegal_valid = 0, credits = RS_DEPTH.
  - in_ready = 0 while rst is low; in_ready = 1 in the first cycle after rst deasserts.
- Reset assertion mid-group discards the group; no partial output.
- illegal_valid/illegal_lane are registered alongside out_valid.
- in_valid with a gap (lane 1 valid, lane 0 invalid) is illegal input; fires an assertion.

Decomposition:
- typedef_pkg additions:
  - rs_class_e enum (CLS_ALU, CLS_LSU, CLS_BRU, CLS_NONE).
  - function classify_opcode(opcode) returning rs_class_e.
  - Opcode constants already live there.
- One sub-module: dispatch_credit_counter (one instance per class). Ports: clk, rst, flush, free_cnt, grant_cnt, credit. Owns saturation and reload.
- Selection logic stays in dispatch_unit as a generate-loop prefix scan.

Test Plan:
1. Config W=2, RS_DEPTH=4, post-reset. Group {ALU ADD, LSU LW} with in_valid=2'b11 at t0 → in_ready=1 at t0; out_valid bit0 (ALU lane0) and bit3 (LSU lane1) high at t1; ALU credit 3, LSU credit 3.
2. Five ALU lanes dispatched, no rs_free → first four dispatch. Group with lane0 ALU and lane1 BRU holds with in_ready=0, and BRU lane1 does NOT dispatch (in-order block). One rs_free ALU pulse → both lanes out at the following cycle; ALU credit 0.
3. Group {ALU, ALU} with ALU credit=1 → lane0 dispatched at t+1, lane1 stays pending, in_ready=0. rs_free ALU in the same cycle as the grant → credit stays 1 net, lane1 dispatches next cycle.
4. flush asserted while lane1 is pending and ALU credit=0 → out_valid=0 next cycle, pending cleared, all credits=4, in_ready=1 the cycle after flush drops.
5. stall_dispatch high for 3 cycles with a valid group offered → in_ready=0, out_valid=0 throughout. Group dispatches 1 cycle after stall drops.
6. Lane0 opcode 7'b0000000 (illegal), lane1 ALU → illegal_valid=1 with illegal_lane=0 and out_valid bit1 high at t+1; no credit consumed for lane0. Also: rst low mid-group → all outputs 0 immediately (asynchronous).
